uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 67 ++++++
 rtl/uart_tx.sv | 134 +++++++++++++
 tb/tb_uart_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmitter types and frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO queueing bytes in front of the UART transmitter.
// Read data is show-ahead: rd_data always presents the head entry.
// DEPTH must be a power of two so the pointers wrap by overflow.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_wr;
  logic             do_rd;

  // Writes while full and reads while empty are dropped.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count;
    case ({do_wr, do_rd})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Storage array; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO.
// The line and status outputs are registered from the FSM state, so they
// trail the state by one cycle; a byte accepted into an empty FIFO reaches
// the line as a falling start edge two cycles after acceptance.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned    BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int unsigned    CW         = cnt_width(BIT_CYCLES);
  localparam int unsigned    IW         = cnt_width(DATA_BITS);
  localparam logic [CW-1:0]  BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0]  DATA_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0]  STOP_LAST  = IW'(STOP_BITS - 1);

  tx_state_t            state;
  logic [CW-1:0]        bit_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 bit_end;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           fifo_rd_data;

  assign tx_ready = !fifo_full;
  assign push     = tx_valid && tx_ready;
  assign pop      = (state == IDLE) && !fifo_empty;
  assign bit_end  = (bit_cnt == BIT_LAST);

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (tx_data),
    .wr_en   (push),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frame sequencer: bit-period counter, bit index and data shifter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
          if (!fifo_empty) begin
            shift <= fifo_rd_data;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            shift   <= shift >> 1;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered line and status outputs decoded from the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_busy <= (state != IDLE);
      tx_done <= (state == STOP) && bit_end && (bit_idx == STOP_LAST);
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a reference
// receiver decodes the serial line and compares in order.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int unsigned CLK_FREQ   = 1_000_000;
  localparam int unsigned BAUD_RATE  = 100_000;
  localparam int unsigned FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_q [$];

  uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold tx_valid with byte b until accepted; tries = edges waited.
  task automatic send(input logic [7:0] b, input bit expect_rx, output int tries);
    bit acc;
    acc      = 1'b0;
    tries    = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!acc && tries < 3000) begin
      acc = tx_ready;
      step();
      tries++;
    end
    check("send_accept", {31'd0, acc}, 32'd1);
    if (acc && expect_rx) exp_q.push_back(b);
  endtask

  // Drop valid and scramble data so queued bytes must not depend on it.
  task automatic idle();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < limit) begin
      step();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  // Reference receiver: samples mid-bit on negedges, aborts on reset.
  initial begin : rx_monitor
    logic       prev;
    logic [7:0] b;
    bit         aborted;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
      end else if (prev === 1'b1 && tx === 1'b0) begin
        aborted = 1'b0;
        b       = '0;
        for (int k = 0; k < 4 && !aborted; k++) begin
          @(negedge clk);
          if (reset) aborted = 1'b1;
        end
        if (!aborted) check("rx_start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8 && !aborted; i++) begin
          for (int k = 0; k < 10 && !aborted; k++) begin
            @(negedge clk);
            if (reset) aborted = 1'b1;
          end
          b[i] = tx;
        end
        for (int k = 0; k < 10 && !aborted; k++) begin
          @(negedge clk);
          if (reset) aborted = 1'b1;
        end
        if (!aborted) begin
          check("rx_stop_bit", {31'd0, tx}, 32'd1);
          if (exp_q.size() == 0) check("rx_unexpected_byte", {24'd0, b}, 32'h100);
          else                   check("rx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
        prev = reset ? 1'b1 : tx;
      end else begin
        prev = tx;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin : stim
    int         n;
    int         tries;
    int         low_cnt;
    int         done_cnt;
    int         busy_cnt;
    logic [9:0] pat;
    logic [7:0] fill [6];

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) step();
    check("reset_tx",    {31'd0, tx},       32'd1);
    check("reset_busy",  {31'd0, tx_busy},  32'd0);
    check("reset_done",  {31'd0, tx_done},  32'd0);
    check("reset_ready", {31'd0, tx_ready}, 32'd1);
    reset = 1'b0;
    repeat (2) step();

    // 0xA5: start, 1,0,1,0,0,1,0,1 LSB first, stop.
    pat = 10'b11_0100_1010;
    send(8'hA5, 1'b1, tries);
    idle();
    n = 0;
    do begin
      step();
      n++;
    end while (tx && n < 20);
    check("a5_latency", n, 2);
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) step();
      if (c % 10 == 5) check($sformatf("a5_bit%0d", c / 10), {31'd0, tx}, {31'd0, pat[c / 10]});
      check("a5_done", {31'd0, tx_done}, (c == 100) ? 32'd1 : 32'd0);
      if (c == 1 || c == 100) check("a5_busy", {31'd0, tx_busy}, 32'd1);
    end
    step();
    check("a5_busy_after", {31'd0, tx_busy}, 32'd0);
    check("a5_tx_after",   {31'd0, tx},      32'd1);
    drain(200);

    // Back-to-back 0x00, 0xFF, 0x55.
    send(8'h00, 1'b1, tries);
    send(8'hFF, 1'b1, tries);
    send(8'h55, 1'b1, tries);
    idle();
    n = 0;
    while (!tx_busy && n < 50) begin step(); n++; end
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (tx_busy && n < 300) begin step(); n++; end
      check($sformatf("b2b_frame%0d_len", f), n, 100);
      if (f < 2) begin
        n = 0;
        while (!tx_busy && n < 20) begin step(); n++; end
        check($sformatf("b2b_gap%0d", f), n, 1);
      end
    end
    drain(200);

    // Fill: 1 in flight + 4 queued, sixth waits for the next pop.
    fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66};
    for (int i = 0; i < 5; i++) begin
      send(fill[i], 1'b1, tries);
      check($sformatf("fill_try%0d", i), tries, 1);
    end
    check("fill_ready_low", {31'd0, tx_ready}, 32'd0);
    send(fill[5], 1'b1, tries);
    check("full_push_wait", tries, 99);
    check("refill_ready_low", {31'd0, tx_ready}, 32'd0);
    idle();
    drain(1000);

    // Reset at frame cycle 45 with two bytes queued.
    send(8'hC3, 1'b0, tries);
    send(8'h3C, 1'b0, tries);
    send(8'h99, 1'b0, tries);
    idle();
    n = 0;
    while (tx && n < 20) begin step(); n++; end
    repeat (44) step();
    reset = 1'b1;
    step();
    check("midreset_tx",    {31'd0, tx},       32'd1);
    check("midreset_busy",  {31'd0, tx_busy},  32'd0);
    check("midreset_ready", {31'd0, tx_ready}, 32'd1);
    done_cnt = tx_done ? 1 : 0;
    reset    = 1'b0;
    low_cnt  = 0;
    busy_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (!tx)     low_cnt++;
      if (tx_done) done_cnt++;
      if (tx_busy) busy_cnt++;
    end
    check("midreset_tx_low_cycles", low_cnt,  0);
    check("midreset_done_pulses",   done_cnt, 0);
    check("midreset_busy_cycles",   busy_cnt, 0);

    // 200 random bytes with random valid gaps.
    for (int i = 0; i < 200; i++) begin
      n = int'($urandom_range(0, 3));
      if (n > 0) begin
        idle();
        repeat (n) step();
      end
      send(8'($urandom), 1'b1, tries);
    end
    idle();
    drain(30000);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
